// File: rtl/data_route_pkg.sv
// Shared definitions for the data-route lane switches: lane count, drop code,
// packet FSM state encoding and skid payload width.
package data_route_pkg;

  localparam int         NLANE     = 3;
  localparam logic [1:0] DEST_DROP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  // Payload is {weight_switch, tdata, tlast}
  function automatic int payload_width(input int dwidth, input int lastw);
    return dwidth + lastw + 1;
  endfunction

endpackage

// File: rtl/in_switch_skid.sv
// Two-entry registered forward/backward slice: one output register plus one
// skid register, registered ready that drops only when both are occupied.
module in_switch_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         load_out;
  logic         skid_valid_d;

  assign in_fire      = s_valid & s_ready;
  assign load_out     = m_ready | ~m_valid;
  assign skid_valid_d = load_out ? 1'b0 : (skid_valid | in_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      s_ready    <= ~skid_valid_d;
      skid_valid <= skid_valid_d;
      if (load_out) begin
        // Skid entry is always older than anything arriving this cycle
        if (skid_valid) begin
          m_data  <= skid_data;
          m_valid <= 1'b1;
        end else begin
          m_valid <= in_fire;
          if (in_fire) m_data <= s_data;
        end
      end else if (in_fire) begin
        skid_data <= s_data;
      end
    end
  end

endmodule

// File: rtl/in_switch.sv
// One-to-three AXI-Stream packet demux with per-lane skid stages, fixed or
// round-robin lane selection and whole-packet drop.
//
//   state | meaning
//   IDLE  | no packet open; destination chosen from dest_mode/dest_sel/rr
//   BUSY  | multi-beat packet open; beats follow the latched destination
//   DROP  | multi-beat packet being discarded; input always ready
module in_switch
  import data_route_pkg::*;
#(
  parameter int DWIDTH = 128,
  parameter int LASTW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dest_mode,
  input  logic [1:0]        dest_sel,
  input  logic              weight_switch,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [LASTW-1:0]  s_axis_tlast,
  output logic [DWIDTH-1:0] m_axis_tdata_0,
  output logic              m_axis_tvalid_0,
  input  logic              m_axis_tready_0,
  output logic [LASTW-1:0]  m_axis_tlast_0,
  output logic              weight_switch_out_0,
  output logic [DWIDTH-1:0] m_axis_tdata_1,
  output logic              m_axis_tvalid_1,
  input  logic              m_axis_tready_1,
  output logic [LASTW-1:0]  m_axis_tlast_1,
  output logic              weight_switch_out_1,
  output logic [DWIDTH-1:0] m_axis_tdata_2,
  output logic              m_axis_tvalid_2,
  input  logic              m_axis_tready_2,
  output logic [LASTW-1:0]  m_axis_tlast_2,
  output logic              weight_switch_out_2,
  output logic              pkt_busy,
  output logic              pkt_drop
);

  localparam int PW = payload_width(DWIDTH, LASTW);

  state_t          state, state_d;
  logic [1:0]      rr, dest, cand, sel;
  logic            mode_q, run;
  logic            eop, accept, route_ready, rr_adv;
  logic [PW-1:0]   s_payload;
  logic [NLANE-1:0] lane_s_valid, lane_s_ready, lane_m_valid, lane_m_ready;
  logic [PW-1:0]   lane_m_data [NLANE];

  assign eop       = |s_axis_tlast;
  assign cand      = dest_mode ? rr : dest_sel;
  assign sel       = (state == BUSY) ? dest : cand;
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign s_payload = {weight_switch, s_axis_tdata, s_axis_tlast};
  assign pkt_busy  = (state != IDLE);

  always_comb begin
    route_ready = 1'b1;
    case (sel)
      2'd0:    route_ready = lane_s_ready[0];
      2'd1:    route_ready = lane_s_ready[1];
      2'd2:    route_ready = lane_s_ready[2];
      default: route_ready = 1'b1;
    endcase
  end

  // run keeps the drop path from advertising ready while in reset
  assign s_axis_tready = run & ((state == DROP) | route_ready);

  assign rr_adv = accept & eop &
                  (((state == IDLE) & dest_mode & (cand != DEST_DROP)) |
                   ((state == BUSY) & mode_q));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && !eop) state_d = (cand == DEST_DROP) ? DROP : BUSY;
      BUSY:    if (accept && eop) state_d = IDLE;
      DROP:    if (accept && eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 2'd0;
      dest     <= 2'd0;
      mode_q   <= 1'b0;
      run      <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      state    <= state_d;
      run      <= 1'b1;
      pkt_drop <= accept & (state == IDLE) & (cand == DEST_DROP);
      if (accept && (state == IDLE) && (cand != DEST_DROP)) begin
        dest   <= cand;
        mode_q <= dest_mode;
      end
      if (rr_adv) rr <= (rr == 2'd2) ? 2'd0 : rr + 2'd1;
    end
  end

  assign lane_m_ready = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign lane_s_valid[k] = s_axis_tvalid & run & (state != DROP) & (sel == 2'(k));

    in_switch_skid #(.W(PW)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (lane_s_valid[k]),
      .s_ready (lane_s_ready[k]),
      .s_data  (s_payload),
      .m_valid (lane_m_valid[k]),
      .m_ready (lane_m_ready[k]),
      .m_data  (lane_m_data[k])
    );
  end

  assign m_axis_tvalid_0     = lane_m_valid[0];
  assign m_axis_tdata_0      = lane_m_data[0][PW-2:LASTW];
  assign weight_switch_out_0 = lane_m_data[0][PW-1];
  assign m_axis_tlast_0      = lane_m_valid[0] ? lane_m_data[0][LASTW-1:0] : '0;

  assign m_axis_tvalid_1     = lane_m_valid[1];
  assign m_axis_tdata_1      = lane_m_data[1][PW-2:LASTW];
  assign weight_switch_out_1 = lane_m_data[1][PW-1];
  assign m_axis_tlast_1      = lane_m_valid[1] ? lane_m_data[1][LASTW-1:0] : '0;

  assign m_axis_tvalid_2     = lane_m_valid[2];
  assign m_axis_tdata_2      = lane_m_data[2][PW-2:LASTW];
  assign weight_switch_out_2 = lane_m_data[2][PW-1];
  assign m_axis_tlast_2      = lane_m_valid[2] ? lane_m_data[2][LASTW-1:0] : '0;

endmodule

// File: tb/tb_in_switch.sv
// Directed bench for in_switch: fixed routing, round-robin, backpressure,
// drop, mid-packet select changes and asynchronous reset.
module tb_in_switch;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dest_mode;
  logic [1:0]    dest_sel;
  logic          weight_switch;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [0:0]    s_axis_tlast;
  logic [DW-1:0] m_axis_tdata_0, m_axis_tdata_1, m_axis_tdata_2;
  logic          m_axis_tvalid_0, m_axis_tvalid_1, m_axis_tvalid_2;
  logic          m_axis_tready_0, m_axis_tready_1, m_axis_tready_2;
  logic [0:0]    m_axis_tlast_0, m_axis_tlast_1, m_axis_tlast_2;
  logic          weight_switch_out_0, weight_switch_out_1, weight_switch_out_2;
  logic          pkt_busy, pkt_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  in_switch #(.DWIDTH(DW), .LASTW(1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dest_mode           (dest_mode),
    .dest_sel            (dest_sel),
    .weight_switch       (weight_switch),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .m_axis_tdata_0      (m_axis_tdata_0),
    .m_axis_tvalid_0     (m_axis_tvalid_0),
    .m_axis_tready_0     (m_axis_tready_0),
    .m_axis_tlast_0      (m_axis_tlast_0),
    .weight_switch_out_0 (weight_switch_out_0),
    .m_axis_tdata_1      (m_axis_tdata_1),
    .m_axis_tvalid_1     (m_axis_tvalid_1),
    .m_axis_tready_1     (m_axis_tready_1),
    .m_axis_tlast_1      (m_axis_tlast_1),
    .weight_switch_out_1 (weight_switch_out_1),
    .m_axis_tdata_2      (m_axis_tdata_2),
    .m_axis_tvalid_2     (m_axis_tvalid_2),
    .m_axis_tready_2     (m_axis_tready_2),
    .m_axis_tlast_2      (m_axis_tlast_2),
    .weight_switch_out_2 (weight_switch_out_2),
    .pkt_busy            (pkt_busy),
    .pkt_drop            (pkt_drop)
  );

  logic [2:0] vv;
  assign vv = {m_axis_tvalid_2, m_axis_tvalid_1, m_axis_tvalid_0};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] rx_data [8];
  logic          rx_last [8];
  int            rcv, acc;
  logic          fin;

  initial begin
    rst_n = 1'b0; dest_mode = 1'b0; dest_sel = 2'd3; weight_switch = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b1; m_axis_tready_2 = 1'b1;
    #2;
    chk("rst_valid", vv, 3'b000);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_data0", m_axis_tdata_0, 0);
    chk("rst_tlast", {m_axis_tlast_2, m_axis_tlast_1, m_axis_tlast_0}, 3'b000);
    chk("rst_ws", {weight_switch_out_2, weight_switch_out_1, weight_switch_out_0}, 3'b000);
    chk("rst_busy_drop", {pkt_busy, pkt_drop}, 2'b00);
    tick(); tick();
    rst_n = 1'b1;
    dest_sel = 2'd1;
    #1;
    chk("rel_tready_pre", s_axis_tready, 1'b0);
    tick();
    chk("rel_tready_post", s_axis_tready, 1'b1);

    // fixed route to lane 1, 4 beats
    s_axis_tvalid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_axis_tdata = DW'(i);
      s_axis_tlast = (i == 4);
      #1;
      chk("t1_tready", s_axis_tready, 1'b1);
      tick();
      chk("t1_valid", vv, 3'b010);
      chk("t1_data", m_axis_tdata_1, i);
      chk("t1_last", m_axis_tlast_1, (i == 4));
      chk("t1_busy", pkt_busy, (i != 4));
    end
    s_axis_tvalid = 1'b0;
    tick();
    chk("t1_drain", vv, 3'b000);

    // round-robin, 1-beat packets, then confirm pointer back at lane 0
    dest_mode = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_axis_tdata = DW'(8'h0A + i);
      tick();
      chk("t2_lane", vv, 3'b001 << (i % 3));
      case (i % 3)
        0: chk("t2_data0", m_axis_tdata_0, 8'h0A + i);
        1: chk("t2_data1", m_axis_tdata_1, 8'h0A + i);
        default: chk("t2_data2", m_axis_tdata_2, 8'h0A + i);
      endcase
    end
    s_axis_tvalid = 1'b0;
    tick();
    // rr now 1 after the seventh packet; return to mode 0 for the rest
    dest_mode = 1'b0;

    // backpressure on lane 2
    dest_sel = 2'd2;
    m_axis_tready_2 = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b0;
    s_axis_tdata = DW'(8'h21);
    tick();
    s_axis_tdata = DW'(8'h22);
    #1;
    chk("t3_tready_b2", s_axis_tready, 1'b1);
    tick();
    s_axis_tdata = DW'(8'h23);
    #1;
    chk("t3_stall_tready", s_axis_tready, 1'b0);
    chk("t3_stall_data", m_axis_tdata_2, 8'h21);
    tick();
    chk("t3_stall_hold", {m_axis_tvalid_2, m_axis_tdata_2}, {1'b1, DW'(8'h21)});
    chk("t3_stall_tready2", s_axis_tready, 1'b0);
    m_axis_tready_2 = 1'b1;
    acc = 2;
    rcv = 0;
    for (int cyc = 0; cyc < 30 && rcv < 5; cyc++) begin
      if (m_axis_tvalid_2) begin
        rx_data[rcv] = m_axis_tdata_2;
        rx_last[rcv] = m_axis_tlast_2[0];
        rcv++;
      end
      fin = s_axis_tvalid & s_axis_tready;
      tick();
      if (fin) begin
        acc++;
        if (acc == 5) s_axis_tvalid = 1'b0;
        else begin
          s_axis_tdata = DW'(8'h21 + acc);
          s_axis_tlast = (acc == 4);
        end
      end
    end
    chk("t3_count", rcv, 5);
    for (int j = 0; j < 5; j++) begin
      if (j < rcv) begin
        chk("t3_order", rx_data[j], 8'h21 + j);
        chk("t3_last", rx_last[j], (j == 4));
      end
    end
    tick();
    chk("t3_idle", {pkt_busy, vv}, 4'b0000);

    // drop a 3-beat packet, then 1-beat packet to lane 0
    dest_sel = 2'd3;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = DW'(8'h31 + i);
      s_axis_tlast = (i == 2);
      #1;
      chk("t4_tready", s_axis_tready, 1'b1);
      tick();
      chk("t4_novalid", vv, 3'b000);
      chk("t4_drop", pkt_drop, (i == 0));
      chk("t4_busy", pkt_busy, (i != 2));
    end
    dest_sel = 2'd0;
    s_axis_tdata = DW'(8'h40);
    s_axis_tlast = 1'b1;
    tick();
    chk("t4_lane0", vv, 3'b001);
    chk("t4_data0", m_axis_tdata_0, 8'h40);
    chk("t4_drop_once", pkt_drop, 1'b0);
    s_axis_tvalid = 1'b0;
    tick();

    // dest_sel changes mid-packet, weight_switch toggles per beat
    dest_sel = 2'd0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = DW'(8'h51 + i);
      s_axis_tlast = (i == 2);
      weight_switch = (i % 2 == 0);
      tick();
      dest_sel = 2'd2;
      chk("t5_lane", vv, 3'b001);
      chk("t5_data", m_axis_tdata_0, 8'h51 + i);
      chk("t5_ws", weight_switch_out_0, (i % 2 == 0));
    end
    s_axis_tvalid = 1'b0;
    weight_switch = 1'b0;
    tick();

    // async reset during beat 2 of a 4-beat packet
    dest_sel = 2'd1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b0;
    s_axis_tdata = DW'(8'h61);
    tick();
    s_axis_tdata = DW'(8'h62);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", vv, 3'b000);
    chk("t6_rst_tready", s_axis_tready, 1'b0);
    chk("t6_rst_busy", pkt_busy, 1'b0);
    s_axis_tvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle", {pkt_busy, vv}, 4'b0000);
    dest_sel = 2'd2;
    s_axis_tdata = DW'(8'h70);
    s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1;
    #1;
    chk("t6_tready", s_axis_tready, 1'b1);
    tick();
    chk("t6_lane", vv, 3'b100);
    chk("t6_data", m_axis_tdata_2, 8'h70);
    chk("t6_last", m_axis_tlast_2, 1'b1);
    chk("t6_busy", pkt_busy, 1'b0);
    s_axis_tvalid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/in_switch.md
Name: in_switch

Overview:
- Splits one AXI-Stream input into three AXI-Stream outputs, routing whole packets. It is the demux counterpart of the three-into-one output merge.
- Sits in front of the three data-route lanes. Each lane receives complete packets, with the weight_switch sideband carried beat-by-beat.
- Each output has a registered skid stage, giving full throughput and timing isolation.

Parameters:
- DWIDTH, 128, tdata width of the input and of every output.
- LASTW, 1, tlast width. End-of-packet (EOP) is |tlast.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- dest_mode  input  1  0 = route by dest_sel; 1 = round-robin across lanes 0, 1, 2.
- dest_sel  input  2  destination lane when dest_mode=0; value 3 = drop.
- weight_switch  input  1  sideband, sampled with each accepted beat.
- s_axis_tdata  input  DWIDTH  input data.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- s_axis_tlast  input  LASTW  input last.
- m_axis_tdata_k  output  DWIDTH  lane k data, k = 0..2.
- m_axis_tvalid_k  output  1  lane k valid.
- m_axis_tready_k  input  1  lane k ready.
- m_axis_tlast_k  output  LASTW  lane k last; forced to 0 while m_axis_tvalid_k=0.
- weight_switch_out_k  output  1  lane k sideband, aligned with m_axis_tdata_k.
- pkt_busy  output  1  high while a multi-beat packet is in progress.
- pkt_drop  output  1  one-cycle pulse when a packet start is dropped.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all m_axis_tvalid_k=0, m_axis_tdata_k=0, m_axis_tlast_k=0, weight_switch_out_k=0;
  - s_axis_tready=0, pkt_busy=0, pkt_drop=0;
  - FSM returns to IDLE; round-robin pointer rr=0.
- Reset release: each skid stage's registered ready becomes 1 at the first rising edge after release.
- Accepted beat = s_axis_tvalid & s_axis_tready at a rising edge.
- FSM states:
  - IDLE: no packet open. Candidate destination cand = rr if dest_mode=1, else dest_sel.
    - Accepted beat with cand in 0..2 is written to lane cand. If the beat is EOP, stay in IDLE; otherwise latch dest=cand and go to BUSY.
    - Accepted beat with cand=3 (only possible in mode 0): beat is discarded and pkt_drop pulses the next cycle. If not EOP, go to DROP; otherwise stay in IDLE.
  - BUSY: beats go to the latched dest. An accepted EOP beat returns the FSM to IDLE.
  - DROP: s_axis_tready=1; beats are discarded. An accepted EOP beat returns the FSM to IDLE.
- Ready routing: s_axis_tready = ready of the selected lane's skid stage (cand in IDLE, dest in BUSY). It is 1 in DROP, and 1 in IDLE when cand=3.
- dest_sel and dest_mode changes take effect only at packet start. Mid-packet changes are ignored.
- rr advances 0→1→2→0 on every accepted EOP beat of a non-dropped packet in mode 1. rr holds in mode 0 and holds on dropped packets.
- Skid stage, one per lane:
  - 2-entry buffer; payload is {weight_switch, tdata, tlast}.
  - Latency is 1 cycle, input beat to m_axis_tvalid_k.
  - Sustains 1 beat/cycle while m_axis_tready_k=1.
  - Registered s_ready drops only when both entries are full.
  - Data and order are preserved across backpressure. Outputs stay stable while tvalid=1 and tready=0.
- Lanes are independent. A stalled lane blocks the input only while a packet is destined to it; other lanes keep draining their buffered beats.
- pkt_busy = (state != IDLE).
- Reset asserted mid-packet: the packet is abandoned, all buffered beats are lost, and there is no partial-packet recovery.

Decomposition:
- Shared package, data_route_pkg:
  - lane count constant NLANE=3;
  - drop code DEST_DROP=2'd3;
  - FSM state enum {IDLE, BUSY, DROP};
  - payload width function DWIDTH+LASTW+1.
- One sub-module: in_switch_skid, a parameterised 2-entry forward/backward registered slice. It is instantiated three times.

Test Plan:
- Mode 0, dest_sel=1, 4-beat packet with tdata 0x1..0x4 and EOP on beat 4, all readies high:
  - m_axis_tvalid_1 rises 1 cycle after the first accept and shows 0x1..0x4 on consecutive cycles;
  - lanes 0 and 2 stay idle;
  - pkt_busy is high from the cycle after beat 1 until the cycle after beat 4.
- Mode 1, six 1-beat packets with tdata 0xA..0xF:
  - lane order is 0, 1, 2, 0, 1, 2;
  - rr=0 afterwards.
- Mode 0, dest_sel=2, m_axis_tready_2=0, 5-beat packet:
  - input accepts 2 beats, then s_axis_tready=0;
  - after tready_2 is asserted, beats arrive in order with no loss or duplication.
- Mode 0, dest_sel=3, 3-beat packet, then dest_sel=0 with a 1-beat packet:
  - pkt_drop pulses once;
  - no output is valid for the first 3 beats;
  - lane 0 receives only the 1-beat packet.
- dest_sel toggles 0→2 mid-packet and weight_switch toggles per beat:
  - whole packet lands on lane 0;
  - weight_switch_out_0 matches per beat.
- Reset asserted during beat 2 of a 4-beat packet:
  - all tvalid drop to 0 immediately (asynchronously);
  - after release the FSM is in IDLE and the next packet routes correctly.
